eq_vector_checker: RTL

//  Self-checking stimulus engine for the 1-bit equality comparator (s = (x == y)).
//  On a start request it drives x/y through 00, 01, 10, 11, holding each vector for HOLD cycles.
//  It samples the comparator result at the end of each hold window and counts mismatches.
//  It sits between control logic (or a bench) and the comparator, and reports pass/fail and the first failing vector.

---
 rtl/eq_vector_checker_if.sv | 25 ++
 rtl/eq_vector_checker.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/eq_vector_checker_if.sv
// Bus between the equality-comparator stimulus engine and its controller/comparator side.
// master = the checker engine, slave = the controller that starts runs and supplies s.
interface eq_vector_checker_if #(
    parameter int ERRW = 8
);
    logic            start;
    logic            s;
    logic            x;
    logic            y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [ERRW-1:0] err_cnt;
    logic [1:0]      fail_vec;

    modport master (
        input  start, s,
        output x, y, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        output start, s,
        input  x, y, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/eq_vector_checker.sv
// Drives x/y through 00,01,10,11 (HOLD cycles each), samples the comparator result s
// on the last cycle of each window, and reports pass, mismatch count and first failing vector.
module eq_vector_checker #(
    parameter int HOLD = 4,
    parameter int ERRW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    eq_vector_checker_if.master   bus
);
    localparam int HCW = $clog2(HOLD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [HCW-1:0]  hc_q, hc_d;
    logic [1:0]      vec_q, vec_d;
    logic            x_q, x_d;
    logic            y_q, y_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [1:0]      fail_q, fail_d;
    logic            seen_q, seen_d;
    logic            mismatch_s;
    logic [1:0]      vec_nx_s;

    // Expected result of a correct comparator for the vector currently driven.
    assign mismatch_s = (bus.s != ~(vec_q[1] ^ vec_q[0]));
    assign vec_nx_s   = vec_q + 2'd1;

    // Next-state and output decode; seen_q tracks first mismatch independently of err_q saturation.
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        vec_d   = vec_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        seen_d  = seen_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    hc_d    = '0;
                    vec_d   = 2'd0;
                    x_d     = 1'b0;
                    y_d     = 1'b0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fail_d  = 2'd0;
                    seen_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (hc_q == HCW'(HOLD - 1)) begin
                    hc_d = '0;
                    if (mismatch_s) begin
                        if (err_q != {ERRW{1'b1}}) begin
                            err_d = err_q + ERRW'(1);
                        end else begin
                            err_d = err_q;
                        end
                        if (!seen_q) begin
                            seen_d = 1'b1;
                            fail_d = vec_q;
                        end else begin
                            seen_d = seen_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    if (vec_q == 2'd3) begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        x_d     = 1'b0;
                        y_d     = 1'b0;
                        pass_d  = !(seen_q || mismatch_s);
                    end else begin
                        vec_d = vec_nx_s;
                        x_d   = vec_nx_s[1];
                        y_d   = vec_nx_s[0];
                    end
                end else begin
                    hc_d = hc_q + HCW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                x_d     = 1'b0;
                y_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hc_q    <= '0;
            vec_q   <= 2'd0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= 2'd0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            vec_q   <= vec_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            seen_q  <= seen_d;
        end
    end

    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail_vec = fail_q;
endmodule
